// File: rtl/debouncer_multi.sv
// debouncer_multi: N-channel debouncer. Each channel has its own synchroniser,
// debounces both press and release, and registers a clean level plus
// single-cycle rise/fall strobes. chg_o flags any strobe on any channel.
module debouncer_multi #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned DELAY       = 3125000,
  parameter int unsigned CNT_W       = 22,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_LEVEL = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [CHANNELS-1:0] d_i,
  output logic [CHANNELS-1:0] d_o,
  output logic [CHANNELS-1:0] rise_o,
  output logic [CHANNELS-1:0] fall_o,
  output logic                chg_o
);

  // Count value on the last cycle before the level is allowed to flip.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    S_STABLE,
    S_COUNT
  } state_t;

  // Per-channel "level flips on this edge" flags; shared with the chg_o register
  // so chg_o lines up exactly with the strobes.
  logic [CHANNELS-1:0] fire_d;
  logic                chg_q;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      state_t                 state_q;
      logic [CNT_W-1:0]       cnt_q;
      logic                   level_q;
      logic                   rise_q;
      logic                   fall_q;
      logic                   s;

      // Only the last synchroniser stage is allowed to feed the filter.
      assign s = sync_q[SYNC_STAGES-1];

      // With DELAY==1 the channel never sits in S_COUNT: the first mismatch fires.
      assign fire_d[gi] = (s != level_q) &&
                          ((DELAY == 1) || ((state_q == S_COUNT) && (cnt_q == CNT_LAST)));

      // Synchroniser chain: bit 0 samples the raw pin, top bit is the clean copy.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          sync_q <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
          sync_q <= {sync_q[SYNC_STAGES-2:0], d_i[gi]};
        end
      end

      // Debounce FSM with registered level and strobes; a bounce back to the
      // current level discards the partial count.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          state_q <= S_STABLE;
          cnt_q   <= '0;
          level_q <= RESET_LEVEL;
          rise_q  <= 1'b0;
          fall_q  <= 1'b0;
        end else begin
          rise_q <= 1'b0;
          fall_q <= 1'b0;
          if (fire_d[gi]) begin
            level_q <= s;
            rise_q  <= s;
            fall_q  <= ~s;
            cnt_q   <= '0;
            state_q <= S_STABLE;
          end else begin
            case (state_q)
              S_STABLE: begin
                if (s != level_q) begin
                  state_q <= S_COUNT;
                  cnt_q   <= CNT_ONE;
                end else begin
                  cnt_q <= '0;
                end
              end
              S_COUNT: begin
                if (s == level_q) begin
                  state_q <= S_STABLE;
                  cnt_q   <= '0;
                end else begin
                  cnt_q <= cnt_q + CNT_ONE;
                end
              end
              default: begin
                state_q <= S_STABLE;
                cnt_q   <= '0;
              end
            endcase
          end
        end
      end

      assign d_o[gi]    = level_q;
      assign rise_o[gi] = rise_q;
      assign fall_o[gi] = fall_q;
    end
  endgenerate

  // Any-channel change flag, registered on the same edge as the strobes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      chg_q <= 1'b0;
    end else begin
      chg_q <= |fire_d;
    end
  end

  assign chg_o = chg_q;

endmodule

// File: tb/tb_debouncer_multi.sv
// tb_debouncer_multi: directed cycle-by-cycle vectors for a 4-channel,
// DELAY=4, 2-stage synchroniser debouncer, plus hand-written corner sequences.
module tb_debouncer_multi;

  logic       clk_i;
  logic       rst_i;
  logic [3:0] d_i;
  logic [3:0] d_o;
  logic [3:0] rise_o;
  logic [3:0] fall_o;
  logic       chg_o;

  int n_checks;
  int n_fail;

  debouncer_multi #(
    .CHANNELS   (4),
    .DELAY      (4),
    .CNT_W      (3),
    .SYNC_STAGES(2),
    .RESET_LEVEL(1'b0)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (d_i),
    .d_o   (d_o),
    .rise_o(rise_o),
    .fall_o(fall_o),
    .chg_o (chg_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // One record: inputs held for n cycles, outputs expected after each of those edges.
  typedef struct {
    int         n;
    logic       rst;
    logic [3:0] d;
    logic [3:0] exp_do;
    logic [3:0] exp_rise;
    logic [3:0] exp_fall;
    logic       exp_chg;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic rst, input logic [3:0] d,
                     input logic [3:0] e_do, input logic [3:0] e_r,
                     input logic [3:0] e_f, input logic e_c);
    vec_t v;
    v.n = n; v.rst = rst; v.d = d;
    v.exp_do = e_do; v.exp_rise = e_r; v.exp_fall = e_f; v.exp_chg = e_c;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_do, input logic [3:0] e_r,
                         input logic [3:0] e_f, input logic e_c);
    chk({tag, " d_o"}, d_o, e_do);
    chk({tag, " rise_o"}, rise_o, e_r);
    chk({tag, " fall_o"}, fall_o, e_f);
    chk({tag, " chg_o"}, {3'b000, chg_o}, {3'b000, e_c});
    chk({tag, " rise&fall"}, rise_o & fall_o, 4'h0);
  endtask

  initial begin
    int edges;
    bit seen;
    n_checks = 0;
    n_fail   = 0;
    rst_i    = 1'b1;
    d_i      = 4'h0;

    //    n  rst d      d_o   rise  fall  chg
    // Reset held with all inputs high, then release: 6 edges to d_o=F.
    add(2, 1, 4'hF, 4'h0, 4'h0, 4'h0, 0);
    add(5, 0, 4'hF, 4'h0, 4'h0, 4'h0, 0);
    add(1, 0, 4'hF, 4'hF, 4'hF, 4'h0, 1);
    add(1, 0, 4'hF, 4'hF, 4'h0, 4'h0, 0);
    // All inputs low: every channel falls together.
    add(5, 0, 4'h0, 4'hF, 4'h0, 4'h0, 0);
    add(1, 0, 4'h0, 4'h0, 4'h0, 4'hF, 1);
    add(1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    // Press on channel 0.
    add(5, 0, 4'h1, 4'h0, 4'h0, 4'h0, 0);
    add(1, 0, 4'h1, 4'h1, 4'h1, 4'h0, 1);
    add(2, 0, 4'h1, 4'h1, 4'h0, 4'h0, 0);
    // Glitch on channel 1: 3 cycles high is too short.
    add(3, 0, 4'h3, 4'h1, 4'h0, 4'h0, 0);
    add(6, 0, 4'h1, 4'h1, 4'h0, 4'h0, 0);
    // Bounce on channel 2: 3 high, 1 low, then held; full restart from final rise.
    add(3, 0, 4'h5, 4'h1, 4'h0, 4'h0, 0);
    add(1, 0, 4'h1, 4'h1, 4'h0, 4'h0, 0);
    add(5, 0, 4'h5, 4'h1, 4'h0, 4'h0, 0);
    add(1, 0, 4'h5, 4'h5, 4'h4, 4'h0, 1);
    add(1, 0, 4'h5, 4'h5, 4'h0, 4'h0, 0);
    // Release of channel 0.
    add(5, 0, 4'h4, 4'h5, 4'h0, 4'h0, 0);
    add(1, 0, 4'h4, 4'h4, 4'h0, 4'h1, 1);
    add(1, 0, 4'h4, 4'h4, 4'h0, 4'h0, 0);
    // 2-cycle release glitch on channel 2 is ignored.
    add(2, 0, 4'h0, 4'h4, 4'h0, 4'h0, 0);
    add(6, 0, 4'h4, 4'h4, 4'h0, 4'h0, 0);
    // Bring channel 1 high.
    add(5, 0, 4'h6, 4'h4, 4'h0, 4'h0, 0);
    add(1, 0, 4'h6, 4'h6, 4'h2, 4'h0, 1);
    add(1, 0, 4'h6, 4'h6, 4'h0, 4'h0, 0);
    // Mixed: channel 3 rises as channel 1 falls; both land on the same edge.
    add(5, 0, 4'hC, 4'h6, 4'h0, 4'h0, 0);
    add(1, 0, 4'hC, 4'hC, 4'h8, 4'h2, 1);
    add(1, 0, 4'hC, 4'hC, 4'h0, 4'h0, 0);
    // Reset pulse mid-count on channel 0: all levels drop, no strobes, full restart.
    add(3, 0, 4'hD, 4'hC, 4'h0, 4'h0, 0);
    add(1, 1, 4'hD, 4'h0, 4'h0, 4'h0, 0);
    add(5, 0, 4'hD, 4'h0, 4'h0, 4'h0, 0);
    add(1, 0, 4'hD, 4'hD, 4'hD, 4'h0, 1);
    add(1, 0, 4'hD, 4'hD, 4'h0, 4'h0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      for (int c = 0; c < vecs[i].n; c++) begin
        @(negedge clk_i);
        rst_i = vecs[i].rst;
        d_i   = vecs[i].d;
        @(posedge clk_i);
        #1;
        chk_all($sformatf("vec%0d.%0d", i, c), vecs[i].exp_do, vecs[i].exp_rise,
                vecs[i].exp_fall, vecs[i].exp_chg);
      end
      $display("vec %0d: rst=%b d_i=%h x%0d -> d_o=%h rise=%h fall=%h chg=%b",
               i, vecs[i].rst, vecs[i].d, vecs[i].n, d_o, rise_o, fall_o, chg_o);
    end

    // Asynchronous reset takes effect without a clock edge.
    @(negedge clk_i);
    rst_i = 1'b1;
    d_i   = 4'hF;
    #1;
    chk_all("async_rst", 4'h0, 4'h0, 4'h0, 1'b0);
    $display("async reset: d_o=%h rise=%h chg=%b", d_o, rise_o, chg_o);
    repeat (2) begin
      @(posedge clk_i);
      #1;
      chk_all("rst_hold", 4'h0, 4'h0, 4'h0, 1'b0);
    end
    // Release with inputs at the reset level: nothing moves, no strobe on release.
    @(negedge clk_i);
    rst_i = 1'b0;
    d_i   = 4'h0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk_i);
      #1;
      chk_all("rst_release_quiet", 4'h0, 4'h0, 4'h0, 1'b0);
    end
    $display("reset release quiet: d_o=%h", d_o);

    // Press latency measured with a bounded wait: must be exactly 6 edges.
    @(negedge clk_i);
    d_i   = 4'h1;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 20) begin
      @(posedge clk_i);
      #1;
      edges++;
      if (rise_o[0]) seen = 1'b1;
    end
    chk("latency_seen", {3'b000, seen}, 4'h1);
    chk("latency_edges", edges[3:0], 4'd6);
    chk("latency_d_o", d_o, 4'h1);
    chk("latency_chg", {3'b000, chg_o}, 4'h1);
    @(posedge clk_i);
    #1;
    chk("latency_rise_drop", rise_o, 4'h0);
    chk("latency_chg_drop", {3'b000, chg_o}, 4'h0);
    $display("latency: rise seen=%b after %0d edges, d_o=%h", seen, edges, d_o);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
